// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the fetch/decode slice of the 5-stage MIPS core.
//   INSTR_W          instruction word width
//   NOP_INSTR        encoding used for ID bubbles (sll $0,$0,0)
//   RESET_PC_DEFAULT default fetch address after reset
//   JADDR_MSB        top bit of the 26-bit J-type target field
//   npc_sel_e        which source drives the next PC
//   ifid_t           contents of the IF/ID pipeline register
//   jump_target()    builds a J-type target from PC+4 and the address field
package mips_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          JADDR_MSB        = 25;

  typedef enum logic [1:0] {
    NPC_SEQ    = 2'd0,
    NPC_BRANCH = 2'd1,
    NPC_JUMP   = 2'd2
  } npc_sel_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pcplus4;
    logic               valid;
  } ifid_t;

  // Only the upper nibble of PC+4 and the address field matter, so callers
  // hand in exactly those bits.
  function automatic logic [31:0] jump_target(input logic [3:0]         pc_hi,
                                              input logic [JADDR_MSB:0] jaddr);
    return {pc_hi, jaddr, 2'b00};
  endfunction

endpackage

// File: rtl/pipe_reg_en_clr.sv
// pipe_reg_en_clr: generic pipeline register.
//   clk  in   rising-edge clock
//   rst  in   asynchronous active-high reset, loads RST_VAL
//   en   in   load enable; en=0 holds the register
//   clr  in   synchronous clear to CLR_VAL, only acts while en=1
//   d    in   W-bit next value
//   q    out  W-bit registered value
// Hold has priority over clear so a stalled stage keeps its contents even
// when a flush request is present.
module pipe_reg_en_clr #(
  parameter int           W       = 32,
  parameter logic [W-1:0] RST_VAL = '0,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= clr ? CLR_VAL : d;
    end
  end

endmodule

// File: rtl/fetch_decode_stage.sv
// fetch_decode_stage: IF stage plus IF/ID register of the 5-stage MIPS core.
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   StallF, StallD      hazard-unit holds for the PC and IF/ID registers
//   PCSrcD, JumpD       taken branch / J-type jump resolved in ID
//   PCBranchD           branch target from ID
//   imem_rdata          instruction at imem_addr (zero-wait combinational ROM)
//   imem_addr, PCF      current fetch PC
//   InstrD, PCPlus4D    instruction in ID and its PC+4
//   ValidD              InstrD is a real instruction rather than a bubble
//   stall_cnt           cycles with StallD=1 (saturating)
//   flush_cnt           cycles in which IF/ID was flushed (saturating)
// Build option: define FETCH_PERF_CNT_EN to implement the two counters;
// without it they are tied to zero and no counter flops exist.
module fetch_decode_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               StallF,
  input  logic               StallD,
  input  logic               PCSrcD,
  input  logic               JumpD,
  input  logic [31:0]        PCBranchD,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [31:0]        imem_addr,
  output logic [31:0]        PCF,
  output logic [INSTR_W-1:0] InstrD,
  output logic [31:0]        PCPlus4D,
  output logic               ValidD,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  logic [31:0] pcplus4f;
  logic [31:0] jump_tgt;
  logic [31:0] pc_next;
  npc_sel_e    npc_sel;
  logic        flush;
  ifid_t       ifid_next;
  ifid_t       ifid_q;

  // PC+4 wraps naturally at 2^32.
  assign pcplus4f = PCF + 32'd4;
  assign jump_tgt = jump_target(PCPlus4D[31:28], InstrD[JADDR_MSB:0]);

  // Jump outranks a simultaneous branch.
  always_comb begin
    npc_sel = NPC_SEQ;
    if (JumpD) begin
      npc_sel = NPC_JUMP;
    end else if (PCSrcD) begin
      npc_sel = NPC_BRANCH;
    end
  end

  always_comb begin
    pc_next = pcplus4f;
    unique case (npc_sel)
      NPC_JUMP:   pc_next = jump_tgt;
      NPC_BRANCH: pc_next = PCBranchD;
      default:    pc_next = pcplus4f;
    endcase
  end

  pipe_reg_en_clr #(
    .W       (32),
    .RST_VAL (RESET_PC),
    .CLR_VAL (RESET_PC)
  ) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .en  (~StallF),
    .clr (1'b0),
    .d   (pc_next),
    .q   (PCF)
  );

  assign imem_addr = PCF;

  // A redirect means the word fetched this cycle is on the wrong path.
  // While ID is stalled the redirect is ignored; it is presented again
  // once the stall clears.
  assign flush = PCSrcD | JumpD;

  assign ifid_next = '{instr: imem_rdata, pcplus4: pcplus4f, valid: 1'b1};

  pipe_reg_en_clr #(
    .W       ($bits(ifid_t)),
    .RST_VAL ({NOP_INSTR, 32'h0, 1'b0}),
    .CLR_VAL ({NOP_INSTR, 32'h0, 1'b0})
  ) u_ifid_reg (
    .clk (clk),
    .rst (rst),
    .en  (~StallD),
    .clr (flush),
    .d   (ifid_next),
    .q   (ifid_q)
  );

  assign InstrD   = ifid_q.instr;
  assign PCPlus4D = ifid_q.pcplus4;
  assign ValidD   = ifid_q.valid;

`ifdef FETCH_PERF_CNT_EN
  logic [1:0]            cnt_inc;
  logic [1:0][CNT_W-1:0] cnt_q;

  assign cnt_inc[0] = StallD;
  assign cnt_inc[1] = flush & ~StallD;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_perf_cnt
      logic [CNT_W-1:0] cnt_reg;

      // Saturate at all-ones rather than wrapping.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg <= '0;
        end else if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
          cnt_reg <= cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end

      assign cnt_q[gi] = cnt_reg;
    end
  endgenerate

  assign stall_cnt = cnt_q[0];
  assign flush_cnt = cnt_q[1];
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_decode_stage.sv
// tb_fetch_decode_stage: self-checking bench for fetch_decode_stage.
// Directed vector table, hand-written reset/saturation sequences, then
// randomized traffic compared against a behavioural model.
module tb_fetch_decode_stage;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          StallF, StallD, PCSrcD, JumpD;
  logic [31:0]   PCBranchD;
  logic [31:0]   imem_rdata;
  logic [31:0]   imem_addr, PCF, InstrD, PCPlus4D;
  logic          ValidD;
  logic [CW-1:0] stall_cnt, flush_cnt;

  logic [31:0] rom [256];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign imem_rdata = rom[imem_addr[9:2]];

  fetch_decode_stage #(
    .RESET_PC (32'h0000_0000),
    .CNT_W    (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .StallF     (StallF),
    .StallD     (StallD),
    .PCSrcD     (PCSrcD),
    .JumpD      (JumpD),
    .PCBranchD  (PCBranchD),
    .imem_rdata (imem_rdata),
    .imem_addr  (imem_addr),
    .PCF        (PCF),
    .InstrD     (InstrD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  typedef struct {
    logic        sf, sd, br, jp;
    logic [31:0] bt;
    logic [31:0] e_pc, e_instr, e_p4;
    logic        e_v;
    int          e_sc, e_fc;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Counter expectation: the counters only count when the feature is built.
  function automatic logic [31:0] cexp(input int v);
`ifdef FETCH_PERF_CNT_EN
    return 32'(v);
`else
    return 32'(v & 0);
`endif
  endfunction

  task automatic drive(input logic sf, input logic sd, input logic br,
                       input logic jp, input logic [31:0] bt);
    StallF = sf; StallD = sd; PCSrcD = br; JumpD = jp; PCBranchD = bt;
  endtask

  // One clock: inputs already driven while clk is low.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference state.
  logic [31:0] m_pc, m_instr, m_p4;
  logic        m_v;
  int          m_sc, m_fc;

  task automatic model_step(input logic sf, input logic sd, input logic br,
                            input logic jp, input logic [31:0] bt);
    logic [31:0] fetched, seq, jt;
    fetched = rom[m_pc[9:2]];
    seq     = m_pc + 32'd4;
    jt      = {m_p4[31:28], m_instr[25:0], 2'b00};
    if (!sf) m_pc = jp ? jt : (br ? bt : seq);
    if (sd) begin
      if (m_sc < (1 << CW) - 1) m_sc++;
    end else if (br || jp) begin
      m_instr = 32'h0; m_p4 = 32'h0; m_v = 1'b0;
      if (m_fc < (1 << CW) - 1) m_fc++;
    end else begin
      m_instr = fetched; m_p4 = seq; m_v = 1'b1;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'hA000_0000 | (i << 2);
    rom[0] = 32'h2008_0005;
    rom[1] = 32'h2009_0003;
    rom[3] = 32'h0800_0040;

    //          sf sd br jp bt             pc             instr          p4             v  sc fc
    tbl[0]  = '{0, 0, 0, 0, 32'h0,         32'h4,         32'h2008_0005, 32'h4,         1, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 32'h0,         32'h8,         32'h2009_0003, 32'h8,         1, 0, 0};
    tbl[2]  = '{1, 1, 0, 0, 32'h0,         32'h8,         32'h2009_0003, 32'h8,         1, 1, 0};
    tbl[3]  = '{0, 0, 0, 0, 32'h0,         32'hC,         32'hA000_0008, 32'hC,         1, 1, 0};
    tbl[4]  = '{0, 0, 0, 0, 32'h0,         32'h10,        32'h0800_0040, 32'h10,        1, 1, 0};
    tbl[5]  = '{0, 0, 1, 1, 32'h200,       32'h100,       32'h0,         32'h0,         0, 1, 1};
    tbl[6]  = '{0, 0, 0, 0, 32'h0,         32'h104,       32'hA000_0100, 32'h104,       1, 1, 1};
    tbl[7]  = '{1, 1, 1, 0, 32'h200,       32'h104,       32'hA000_0100, 32'h104,       1, 2, 1};
    tbl[8]  = '{0, 0, 1, 0, 32'h200,       32'h200,       32'h0,         32'h0,         0, 2, 2};
    tbl[9]  = '{0, 0, 0, 0, 32'h0,         32'h204,       32'hA000_0200, 32'h204,       1, 2, 2};
    tbl[10] = '{0, 0, 1, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,         32'h0,         0, 2, 3};
    tbl[11] = '{0, 0, 0, 0, 32'h0,         32'h0,         32'hA000_03FC, 32'h0,         1, 2, 3};

    rst = 1'b1;
    drive(0, 0, 0, 0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pcf",    PCF,             32'h0);
    chk("reset_instrd", InstrD,          32'h0);
    chk("reset_p4d",    PCPlus4D,        32'h0);
    chk("reset_validd", {31'h0, ValidD}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].sf, tbl[i].sd, tbl[i].br, tbl[i].jp, tbl[i].bt);
      tick();
      $display("vec %0d: pcf=%h instrd=%h p4d=%h v=%0b sc=%0d fc=%0d",
               i, PCF, InstrD, PCPlus4D, ValidD, stall_cnt, flush_cnt);
      chk($sformatf("vec%0d_pcf", i),    PCF,             tbl[i].e_pc);
      chk($sformatf("vec%0d_addr", i),   imem_addr,       tbl[i].e_pc);
      chk($sformatf("vec%0d_instrd", i), InstrD,          tbl[i].e_instr);
      chk($sformatf("vec%0d_p4d", i),    PCPlus4D,        tbl[i].e_p4);
      chk($sformatf("vec%0d_validd", i), {31'h0, ValidD}, {31'h0, tbl[i].e_v});
      chk($sformatf("vec%0d_stallcnt", i), 32'(stall_cnt), cexp(tbl[i].e_sc));
      chk($sformatf("vec%0d_flushcnt", i), 32'(flush_cnt), cexp(tbl[i].e_fc));
      @(negedge clk);
    end

    // Run sequentially up to PCF=0x40, then reset asynchronously mid-cycle.
    drive(0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 64 && PCF != 32'h40; i++) begin
      tick();
      @(negedge clk);
    end
    chk("midrst_reach_pcf", PCF, 32'h40);
    #2;
    rst = 1'b1;
    #1;
    $display("async reset: pcf=%h instrd=%h v=%0b", PCF, InstrD, ValidD);
    chk("midrst_pcf",      PCF,             32'h0);
    chk("midrst_instrd",   InstrD,          32'h0);
    chk("midrst_p4d",      PCPlus4D,        32'h0);
    chk("midrst_validd",   {31'h0, ValidD}, 32'h0);
    chk("midrst_stallcnt", 32'(stall_cnt),  32'h0);
    chk("midrst_flushcnt", 32'(flush_cnt),  32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    $display("after release: pcf=%h instrd=%h v=%0b", PCF, InstrD, ValidD);
    chk("release_pcf",    PCF,             32'h4);
    chk("release_instrd", InstrD,          32'h2008_0005);
    chk("release_p4d",    PCPlus4D,        32'h4);
    chk("release_validd", {31'h0, ValidD}, 32'h1);
    @(negedge clk);

    // Long stall: stall counter saturates, PC and IF/ID hold.
    drive(1, 1, 0, 0, 32'h0);
    repeat (20) tick();
    $display("long stall: pcf=%h instrd=%h sc=%0d", PCF, InstrD, stall_cnt);
    chk("sat_pcf",      PCF,            32'h4);
    chk("sat_instrd",   InstrD,         32'h2008_0005);
    chk("sat_stallcnt", 32'(stall_cnt), cexp((1 << CW) - 1));
    chk("sat_flushcnt", 32'(flush_cnt), 32'h0);
    @(negedge clk);

    // Randomized traffic against the model.
    rst = 1'b1;
    drive(0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    @(negedge clk);
    rst = 1'b0;
    m_pc = 32'h0; m_instr = 32'h0; m_p4 = 32'h0; m_v = 1'b0; m_sc = 0; m_fc = 0;
    for (int n = 0; n < 400; n++) begin
      logic sf, sd, br, jp;
      logic [31:0] bt;
      sd = ($urandom_range(0, 5) == 0);
      sf = sd | ($urandom_range(0, 19) == 0);
      br = ($urandom_range(0, 3) == 0);
      jp = ($urandom_range(0, 7) == 0);
      bt = $urandom & 32'hFFFF_FFFC;
      drive(sf, sd, br, jp, bt);
      model_step(sf, sd, br, jp, bt);
      tick();
      $display("rnd %0d: sf=%0b sd=%0b br=%0b jp=%0b pcf=%h instrd=%h v=%0b",
               n, sf, sd, br, jp, PCF, InstrD, ValidD);
      chk("rnd_pcf",      PCF,             m_pc);
      chk("rnd_addr",     imem_addr,       m_pc);
      chk("rnd_instrd",   InstrD,          m_instr);
      chk("rnd_p4d",      PCPlus4D,        m_p4);
      chk("rnd_validd",   {31'h0, ValidD}, {31'h0, m_v});
      chk("rnd_stallcnt", 32'(stall_cnt),  cexp(m_sc));
      chk("rnd_flushcnt", 32'(flush_cnt),  cexp(m_fc));
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
